fg_prog_sequencer: RTL and testbench



---
 rtl/fg_prog_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one analog island: it applies timed
// injection pulses to one device per command and then returns the island to run mode.
module fg_prog_sequencer #(
    parameter int unsigned DRAIN_BITS = 5,
    parameter int unsigned GATE_BITS  = 2,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned GAP_CYC    = 8,
    parameter int unsigned PW_W       = 8,
    parameter int unsigned NP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DRAIN_BITS-1:0] cmd_drain,
    input  logic [GATE_BITS-1:0]  cmd_gate,
    input  logic [PW_W-1:0]       cmd_pw,
    input  logic [NP_W-1:0]       cmd_np,
    input  logic                  abort,
    output logic [DRAIN_BITS-1:0] drain_b,
    output logic [GATE_BITS-1:0]  gate_b,
    output logic                  drain_en,
    output logic                  gate_en,
    output logic                  prog,
    output logic                  run,
    output logic                  vg_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [NP_W-1:0]       pulse_cnt
);

    localparam int unsigned PW_MAX  = (1 << PW_W) - 1;
    localparam int unsigned SG_MAX  = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int unsigned CNT_MAX = (SG_MAX > PW_MAX) ? SG_MAX : PW_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_RECOVER
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [PW_W-1:0]  pw_q;
    logic [NP_W-1:0]  np_q;
    logic             ab_q, ab_nx;
    logic             accept, pc_inc, done_nx;
    logic             prog_d, run_d, vg_sel_d, gate_en_d, drain_en_d;
    logic             busy_d, ready_d, aborted_d;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pw_q      <= '0;
            np_q      <= '0;
            ab_q      <= 1'b0;
            drain_b   <= '0;
            gate_b    <= '0;
            drain_en  <= 1'b0;
            gate_en   <= 1'b0;
            prog      <= 1'b0;
            run       <= 1'b1;
            vg_sel    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cmd_ready <= 1'b1;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ab_q      <= ab_nx;
            drain_en  <= drain_en_d;
            gate_en   <= gate_en_d;
            prog      <= prog_d;
            run       <= run_d;
            vg_sel    <= vg_sel_d;
            busy      <= busy_d;
            done      <= done_nx;
            aborted   <= aborted_d;
            cmd_ready <= ready_d;
            if (accept) begin
                pw_q      <= (cmd_pw == '0) ? PW_W'(1) : cmd_pw;
                np_q      <= cmd_np;
                pulse_cnt <= '0;
                // A zero-pulse command must leave the island pins untouched.
                if (cmd_np != '0) begin
                    drain_b <= cmd_drain;
                    gate_b  <= cmd_gate;
                end
            end else if (pc_inc) begin
                pulse_cnt <= pulse_cnt + NP_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        ab_nx    = ab_q;
        pc_inc   = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_nx = cnt;
                if (accept) begin
                    ab_nx = 1'b0;
                    if (cmd_np == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_SETUP;
                        cnt_nx   = SETTLE_LOAD;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_nx = S_RECOVER;
                    cnt_nx   = SETTLE_LOAD;
                    ab_nx    = 1'b1;
                end else if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(pw_q) - CNT_W'(1);
                end
            end
            S_PULSE: begin
                // The final pulse cycle still counts as a completed pulse even if aborted.
                if (cnt == '0) begin
                    pc_inc = 1'b1;
                    if (abort || (pulse_cnt + NP_W'(1)) == np_q) begin
                        state_nx = S_RECOVER;
                        cnt_nx   = SETTLE_LOAD;
                    end else begin
                        state_nx = S_GAP;
                        cnt_nx   = GAP_LOAD;
                    end
                    if (abort) ab_nx = 1'b1;
                end else if (abort) begin
                    state_nx = S_RECOVER;
                    cnt_nx   = SETTLE_LOAD;
                    ab_nx    = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nx = S_RECOVER;
                    cnt_nx   = SETTLE_LOAD;
                    ab_nx    = 1'b1;
                end else if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(pw_q) - CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs decode the upcoming state so every island control is a plain flop.
    always_comb begin
        prog_d     = (state_nx == S_SETUP) || (state_nx == S_PULSE) || (state_nx == S_GAP);
        run_d      = !prog_d;
        vg_sel_d   = prog_d;
        gate_en_d  = prog_d;
        drain_en_d = (state_nx == S_PULSE);
        busy_d     = (state_nx != S_IDLE);
        ready_d    = (state_nx == S_IDLE);
        aborted_d  = done_nx && ab_nx;
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Scoreboard bench for fg_prog_sequencer: a driver queues per-command expectations
// from a timeline model; a negedge monitor measures each command and compares at done.
module tb_fg_prog_sequencer;

    localparam int S = 16;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_drain = '0;
    logic [1:0] cmd_gate = '0;
    logic [7:0] cmd_pw = '0;
    logic [5:0] cmd_np = '0;
    logic       abort = 1'b0;
    logic [4:0] drain_b;
    logic [1:0] gate_b;
    logic       drain_en, gate_en, prog, run, vg_sel, busy, done, aborted;
    logic [5:0] pulse_cnt;

    always #5 clk = ~clk;

    fg_prog_sequencer #(
        .DRAIN_BITS(5), .GATE_BITS(2), .SETTLE_CYC(S), .GAP_CYC(G), .PW_W(8), .NP_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_drain(cmd_drain), .cmd_gate(cmd_gate), .cmd_pw(cmd_pw), .cmd_np(cmd_np),
        .abort(abort), .drain_b(drain_b), .gate_b(gate_b), .drain_en(drain_en),
        .gate_en(gate_en), .prog(prog), .run(run), .vg_sel(vg_sel), .busy(busy),
        .done(done), .aborted(aborted), .pulse_cnt(pulse_cnt)
    );

    typedef struct {
        int lat; int ab; int pc; int hi; int npulse; int pfirst; int pwe; int d; int g;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int active_len(input int pw, input int np);
        int pwe;
        pwe = (pw == 0) ? 1 : pw;
        return (np == 0) ? 0 : S + np * pwe + (np - 1) * G;
    endfunction

    function automatic bit is_pulse_end(input int k, input int pw, input int np);
        int pwe;
        pwe = (pw == 0) ? 1 : pw;
        for (int j = 0; j < np; j++)
            if (k == S + 1 + j * (pwe + G) + pwe - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Timeline model: cycle 1 is the first cycle after the accept edge.
    function automatic exp_t model(input int d, input int g, input int pw, input int np, input int k);
        exp_t e;
        int   pwe, t_act, st, en;
        pwe = (pw == 0) ? 1 : pw;
        e.d = d; e.g = g; e.pwe = pwe; e.ab = 0; e.pc = 0; e.hi = 0;
        e.npulse = 0; e.pfirst = 0; e.lat = 1;
        if (np != 0) begin
            t_act = active_len(pw, np);
            e.pfirst = 1;
            if (k == 0 || k > t_act) begin
                e.lat = t_act + S + 1; e.pc = np; e.hi = np * pwe; e.npulse = np;
            end else begin
                e.lat = k + S + 1; e.ab = 1;
                for (int j = 0; j < np; j++) begin
                    st = S + 1 + j * (pwe + G);
                    en = st + pwe - 1;
                    if (st <= k) begin
                        e.npulse++;
                        e.hi += ((en < k) ? en : k) - st + 1;
                    end
                    if (en <= k) e.pc++;
                end
            end
        end
        return e;
    endfunction

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // Entered at posedge+1 with cmd_ready high; returns at posedge+1 of the done cycle
    // (or later if idle_after > 0).
    task automatic issue(input int d, input int g, input int pw, input int np, input int k,
                         input bit garbage, input int idle_after);
        exp_t e;
        int   t_act;
        e = model(d, g, pw, np, k);
        t_act = active_len(pw, np);
        cmd_drain = 5'(d); cmd_gate = 2'(g); cmd_pw = 8'(pw); cmd_np = 6'(np);
        cmd_valid = 1'b1;
        abort = 1'($urandom_range(0, 1));
        exp_q.push_back(e);
        @(posedge clk); #1;
        for (int c = 1; ; c++) begin
            if (cmd_ready) break;
            if (c > e.lat + 8) begin
                n_fail++;
                $display("FAIL drv_timeout: cmd_ready still 0 at cycle %0d, expected 1 by %0d", c, e.lat);
                finish_now();
            end
            abort = (k != 0) ? (c == k) : (c > t_act && $urandom_range(0, 3) == 0);
            if (garbage) begin
                cmd_valid = 1'b1;
                cmd_drain = 5'($urandom); cmd_gate = 2'($urandom);
                cmd_pw = 8'($urandom); cmd_np = 6'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
        if (idle_after > 0) begin
            repeat (idle_after) @(posedge clk);
            #1;
        end
    endtask

    // Monitor state
    int   cyc, hi, npulse, pfirst, low_run, hi_run;
    bit   trk = 0, acc_prev = 0, de_prev = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            trk = 0; acc_prev = 0; de_prev = 0;
        end else begin
            if (acc_prev) begin
                trk = 1; cyc = 1; hi = 0; npulse = 0; pfirst = 0;
                low_run = 0; hi_run = 0; de_prev = 0;
            end else begin
                cyc++;
            end
            acc_prev = 0;
            chk("prog_run_exclusive", int'(prog && run), 0);
            chk("drain_en_needs_prog", int'(drain_en && !prog), 0);
            if (trk && exp_q.size() == 0) begin
                chk("scoreboard_empty_while_tracking", 0, 1);
                trk = 0;
            end
            if (trk) begin
                cur = exp_q[0];
                if (busy) begin
                    chk("drain_b_busy", int'(drain_b), cur.d);
                    chk("gate_b_busy", int'(gate_b), cur.g);
                end
                if (prog && pfirst == 0) pfirst = cyc;
                if (drain_en && !de_prev) begin
                    npulse++;
                    if (npulse > 1) chk("gap_len", low_run, G);
                    hi_run = 0;
                end
                if (!drain_en && de_prev && !cur.ab) chk("pulse_width", hi_run, cur.pwe);
                if (drain_en) begin hi++; hi_run++; low_run = 0; end
                else low_run++;
                de_prev = drain_en;
                if (done) begin
                    void'(exp_q.pop_front());
                    chk("done_latency", cyc, cur.lat);
                    chk("aborted", int'(aborted), cur.ab);
                    chk("pulse_cnt", int'(pulse_cnt), cur.pc);
                    chk("drain_en_cycles", hi, cur.hi);
                    chk("pulse_count_seen", npulse, cur.npulse);
                    chk("prog_first_cycle", pfirst, cur.pfirst);
                    chk("cmd_ready_at_done", int'(cmd_ready), 1);
                    chk("run_at_done", int'(run), 1);
                    if (cur.pfirst != 0) begin
                        chk("drain_b_at_done", int'(drain_b), cur.d);
                        chk("gate_b_at_done", int'(gate_b), cur.g);
                    end
                    trk = 0;
                end else if (cyc > cur.lat + 4) begin
                    chk("done_timeout", cyc, cur.lat);
                    void'(exp_q.pop_front());
                    trk = 0;
                end
            end else if (done) begin
                chk("unexpected_done", 1, 0);
            end
            if (cmd_valid && cmd_ready) acc_prev = 1;
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_now();
    end

    initial begin
        int np, pw, k, t_act;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prog", int'(prog), 0);
        chk("rst_run", int'(run), 1);
        chk("rst_vg_sel", int'(vg_sel), 0);
        chk("rst_drain_en", int'(drain_en), 0);
        chk("rst_gate_en", int'(gate_en), 0);
        chk("rst_addr", int'({drain_b, gate_b}), 0);
        chk("rst_busy_done_ab", int'({busy, done, aborted}), 0);
        chk("rst_pulse_cnt", int'(pulse_cnt), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(19, 2, 4, 3, 0, 0, 2);       // nominal: done at cycle 61
        issue(7, 1, 5, 0, 0, 0, 1);        // zero pulses
        issue(3, 0, 0, 2, 0, 0, 1);        // pw=0 behaves as 1
        issue(10, 3, 10, 5, 36, 0, 0);     // abort in 2nd cycle of pulse 2
        issue(21, 1, 6, 2, 0, 1, 0);       // garbage on cmd inputs while busy
        issue(4, 2, 3, 1, 0, 0, 1);        // back-to-back on done cycle
        issue(9, 1, 2, 3, 5, 0, 1);        // abort in SETUP
        issue(12, 0, 3, 3, S + 3 + 4, 0, 1); // abort in GAP
        issue(1, 1, 255, 1, 0, 0, 1);      // widest pulse
        issue(30, 3, 1, 63, 0, 0, 1);      // maximum pulse count

        // Asynchronous reset mid-pulse
        exp_q.push_back(model(17, 1, 6, 3, 0));
        cmd_drain = 5'd17; cmd_gate = 2'd1; cmd_pw = 8'd6; cmd_np = 6'd3; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 60 && !drain_en; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_drain_en", int'(drain_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_drain_en", int'(drain_en), 0);
        chk("arst_prog", int'(prog), 0);
        chk("arst_run", int'(run), 1);
        chk("arst_vg_sel", int'(vg_sel), 0);
        chk("arst_ready_busy", int'({cmd_ready, busy}), 2);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(19, 2, 4, 3, 0, 0, 1);

        for (int i = 0; i < 30; i++) begin
            np = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            pw = $urandom_range(0, 12);
            k = 0;
            if (np != 0 && $urandom_range(0, 2) == 0) begin
                t_act = active_len(pw, np);
                k = $urandom_range(1, t_act);
                if (is_pulse_end(k, pw, np)) k--;
            end
            issue($urandom_range(0, 31), $urandom_range(0, 3), pw, np, k,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        finish_now();
    end

endmodule
